// File: rtl/reg_cmd_reader_pkg.sv
// Shared definitions for the r29 command reader: command word field
// positions, opcodes, FSM state encodings and the queued command layout.
package reg_cmd_reader_pkg;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 28;
    localparam int N_MSB  = 23;
    localparam int N_LSB  = 0;
    localparam int OP_W   = OP_MSB - OP_LSB + 1;
    localparam int N_W    = N_MSB - N_LSB + 1;
    localparam int CMD_W  = OP_W + N_W;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ON    = 4'd1,
        OP_OFF   = 4'd2,
        OP_BLINK = 4'd3,
        OP_CLEAR = 4'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ON     = 3'd1,
        ST_OFF    = 3'd2,
        ST_BL_ON  = 3'd3,
        ST_BL_OFF = 3'd4
    } state_e;

    // What actually sits in the FIFO: reserved bits [27:24] are dropped.
    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [N_W-1:0]  n;
    } cmd_t;

    // Only timed light actions are queued; CLEAR acts immediately and
    // every other opcode is discarded at capture.
    function automatic logic is_queued_op(input logic [OP_W-1:0] op);
        return (op == OP_ON) || (op == OP_OFF) || (op == OP_BLINK);
    endfunction

endpackage

// File: rtl/reg_cmd_reader_if.sv
// Regfile write-port snoop bus.
//   we   : regfile write enable
//   rd   : regfile write index
//   data : regfile write data
// master = the regfile side driving the write, slave = the snooper.
interface reg_cmd_reader_if;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;

    modport master (output we, rd, data);
    modport slave  (input  we, rd, data);
endinterface

// File: rtl/reg_cmd_reader_cmd_fifo.sv
// cmd_fifo: small synchronous FIFO holding captured commands.
//   clk, reset_n : clock, synchronous active-low reset
//   push, din    : write request and data (accepted when not full, or
//                  when a pop frees a slot on the same edge)
//   pop, dout    : read request; dout shows the head combinationally
//   flush        : empties the FIFO, overrides push and pop
//   full, empty  : status flags
//   level        : number of stored entries, 0..DEPTH
// DEPTH must be a power of 2; pointers carry one extra wrap bit so that
// full and empty are distinguishable.
module cmd_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/reg_cmd_reader.sv
// reg_cmd_reader: processor -> game light command path.
// Snoops regfile writes to CMD_REG, queues ON/OFF/BLINK commands and plays
// them out on the light as timed actions; CLEAR flushes and aborts at once.
//   clk, reset_n : processor clock, synchronous active-low reset
//   snoop        : regfile write-port snoop bus (slave)
//   light        : game light drive
//   busy         : FIFO non-empty or a command executing
//   done         : one-cycle pulse when a command completes normally
//   overflow     : sticky, a command was dropped on a full FIFO
//   fifo_level   : queued entries
//   status       : {overflow, busy, zeros, fifo_level} for software readback
//
// state     | meaning
// ST_IDLE   | no command running; pops and loads the FIFO head
// ST_ON     | light on for n units
// ST_OFF    | light off for n units
// ST_BL_ON  | on half of a blink period (BLINK_UNITS units)
// ST_BL_OFF | off half of a blink period; counts down remaining periods
module reg_cmd_reader
    import reg_cmd_reader_pkg::*;
#(
    parameter logic [4:0] CMD_REG     = 5'd29,
    parameter int         TICK_CYCLES = 25000,
    parameter int         BLINK_UNITS = 250,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    reg_cmd_reader_if.slave               snoop,
    output logic                          light,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   status
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0]    TICK_LAST  = 32'(TICK_CYCLES - 1);
    localparam logic [N_W-1:0] BLINK_LOAD = N_W'(BLINK_UNITS);
    localparam logic [N_W-1:0] N_ONE      = {{(N_W-1){1'b0}}, 1'b1};

    logic            cap;
    logic [OP_W-1:0] cap_op;
    cmd_t            cap_cmd;
    cmd_t            head;
    logic            is_push;
    logic            is_clear;
    logic            pop;
    logic            push_drop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            unused_reserved;

    state_e          state;
    logic [31:0]     prescaler;
    logic [N_W-1:0]  unit_cnt;
    logic [N_W-1:0]  blink_cnt;
    logic            tick;
    logic            unit_last;

    assign cap       = snoop.we && (snoop.rd == CMD_REG);
    assign cap_op    = snoop.data[OP_MSB:OP_LSB];
    assign cap_cmd   = '{op: cap_op, n: snoop.data[N_MSB:N_LSB]};
    assign is_push   = cap && is_queued_op(cap_op);
    assign is_clear  = cap && (cap_op == OP_CLEAR);
    // CLEAR on the same edge suppresses the pop so the head is flushed, not run.
    assign pop       = (state == ST_IDLE) && !fifo_empty && !is_clear;
    assign push_drop = is_push && fifo_full && !pop;
    assign unused_reserved = ^snoop.data[27:24];

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (is_push),
        .pop     (pop),
        .flush   (is_clear),
        .din     (cap_cmd),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign tick      = (prescaler == TICK_LAST);
    assign unit_last = (unit_cnt == N_ONE);
    assign busy      = !fifo_empty || (state != ST_IDLE);
    assign status    = {overflow, busy, {(30-LW){1'b0}}, fifo_level};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            light     <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            prescaler <= '0;
            unit_cnt  <= '0;
            blink_cnt <= '0;
        end else if (is_clear) begin
            state     <= ST_IDLE;
            light     <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            prescaler <= '0;
            unit_cnt  <= '0;
            blink_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (push_drop) overflow <= 1'b1;

            if (state != ST_IDLE) prescaler <= tick ? '0 : prescaler + 32'd1;

            case (state)
                ST_IDLE: begin
                    prescaler <= '0;
                    unit_cnt  <= '0;
                    if (pop) begin
                        if (head.n == '0) begin
                            done <= 1'b1;
                        end else begin
                            case (op_e'(head.op))
                                OP_ON: begin
                                    state    <= ST_ON;
                                    light    <= 1'b1;
                                    unit_cnt <= head.n;
                                end
                                OP_OFF: begin
                                    state    <= ST_OFF;
                                    light    <= 1'b0;
                                    unit_cnt <= head.n;
                                end
                                OP_BLINK: begin
                                    state     <= ST_BL_ON;
                                    light     <= 1'b1;
                                    unit_cnt  <= BLINK_LOAD;
                                    blink_cnt <= head.n;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_ON, ST_OFF: begin
                    if (tick) begin
                        if (unit_last) begin
                            state <= ST_IDLE;
                            light <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            unit_cnt <= unit_cnt - N_ONE;
                        end
                    end
                end
                ST_BL_ON: begin
                    if (tick) begin
                        if (unit_last) begin
                            state    <= ST_BL_OFF;
                            light    <= 1'b0;
                            unit_cnt <= BLINK_LOAD;
                        end else begin
                            unit_cnt <= unit_cnt - N_ONE;
                        end
                    end
                end
                ST_BL_OFF: begin
                    if (tick) begin
                        if (unit_last) begin
                            if (blink_cnt == N_ONE) begin
                                state <= ST_IDLE;
                                done  <= 1'b1;
                            end else begin
                                state    <= ST_BL_ON;
                                light    <= 1'b1;
                                unit_cnt <= BLINK_LOAD;
                            end
                            blink_cnt <= blink_cnt - N_ONE;
                        end else begin
                            unit_cnt <= unit_cnt - N_ONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    light <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_cmd_reader.sv
// Bench for reg_cmd_reader with TICK_CYCLES=4, BLINK_UNITS=2.
// The reference model expands each dequeued command into its full light
// waveform (one bit per cycle) and plays it back, alongside a plain queue
// for the pending commands.
module tb_reg_cmd_reader;
    localparam int T     = 4;
    localparam int BU    = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        light;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [2:0]  fifo_level;
    logic [31:0] status;

    reg_cmd_reader_if snoop_if ();

    reg_cmd_reader #(
        .CMD_REG     (5'd29),
        .TICK_CYCLES (T),
        .BLINK_UNITS (BU),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .snoop      (snoop_if),
        .light      (light),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .fifo_level (fifo_level),
        .status     (status)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { int op; int n; } mcmd_t;
    mcmd_t m_q[$];
    bit    m_sched[$];
    int    m_pos;
    bit    m_active, m_light, m_done, m_ovf, m_valid;

    int light_cnt = 0;
    int done_cnt  = 0;
    int busy_cnt  = 0;
    int max_level = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Predicts the observable state right after the next clock edge.
    function automatic void model_apply(input bit rst_v, input bit we,
                                        input logic [4:0] rd, input logic [31:0] data);
        logic [31:0] d;
        int  op;
        int  n;
        bit  cap;
        bit  popped;
        mcmd_t c;
        d   = data;
        op  = int'(d[31:28]);
        n   = int'(d[23:0]);
        cap = we && (rd == 5'd29);
        if (!rst_v) begin
            m_q.delete(); m_sched.delete();
            m_active = 0; m_light = 0; m_done = 0; m_ovf = 0; m_pos = 0;
            m_valid  = 1;
            return;
        end
        if (cap && op == 4) begin
            m_q.delete(); m_sched.delete();
            m_active = 0; m_light = 0; m_done = 0; m_ovf = 0;
            return;
        end
        m_done = 0;
        popped = 0;
        if (m_active) begin
            m_pos++;
            if (m_pos == m_sched.size()) begin
                m_active = 0; m_done = 1; m_light = 0;
            end else begin
                m_light = m_sched[m_pos];
            end
        end else if (m_q.size() > 0) begin
            c = m_q.pop_front();
            popped = 1;
            if (c.n == 0) begin
                m_done = 1;
            end else begin
                m_sched.delete();
                case (c.op)
                    1: repeat (c.n * T) m_sched.push_back(1'b1);
                    2: repeat (c.n * T) m_sched.push_back(1'b0);
                    3: repeat (c.n) begin
                           repeat (BU * T) m_sched.push_back(1'b1);
                           repeat (BU * T) m_sched.push_back(1'b0);
                       end
                    default: ;
                endcase
                m_active = 1; m_pos = 0; m_light = m_sched[0];
            end
        end
        if (cap && op >= 1 && op <= 3) begin
            if (m_q.size() < DEPTH) m_q.push_back('{op: op, n: n});
            else m_ovf = 1;
        end
        if (popped) ;
    endfunction

    function automatic logic [63:0] exp_outs();
        logic       b;
        logic [2:0] lv;
        b  = (m_q.size() != 0) || m_active;
        lv = 3'(m_q.size());
        return {25'b0, m_light, m_done, b, m_ovf, lv, m_ovf, b, 27'b0, lv};
    endfunction

    task automatic step(input bit rst_v, input bit we, input logic [4:0] rd, input logic [31:0] data);
        @(negedge clk);
        if (m_valid) begin
            check("outputs", {25'b0, light, done, busy, overflow, fifo_level, status}, exp_outs());
            if (light) light_cnt++;
            if (done)  done_cnt++;
            if (busy)  busy_cnt++;
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        end
        reset_n       = rst_v;
        snoop_if.we   = we;
        snoop_if.rd   = rd;
        snoop_if.data = data;
        model_apply(rst_v, we, rd, data);
    endtask

    task automatic put(input logic [4:0] rd, input logic [31:0] data);
        step(1'b1, 1'b1, rd, data);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) step(1'b1, 1'b0, 5'd0, 32'd0);
    endtask

    int lc, dc, bc;

    initial begin
        reset_n       = 1'b0;
        snoop_if.we   = 1'b0;
        snoop_if.rd   = 5'd0;
        snoop_if.data = 32'd0;
        m_valid       = 0;
        model_apply(1'b0, 1'b0, 5'd0, 32'd0);
        repeat (3) step(1'b0, 1'b0, 5'd0, 32'd0);
        check("reset_status", status, 64'd0);
        check("reset_light", light, 64'd0);
        idle(2);

        // ON n=3: 12 cycles high, one done, load one edge after capture.
        lc = light_cnt; dc = done_cnt;
        put(5'd29, 32'h1000_0003);
        idle(1);
        check("lat_level", fifo_level, 64'd1);
        check("lat_light_pre", light, 64'd0);
        idle(1);
        check("lat_light_on", light, 64'd1);
        check("lat_level_pop", fifo_level, 64'd0);
        idle(20);
        check("on3_light_cycles", light_cnt - lc, 64'd12);
        check("on3_dones", done_cnt - dc, 64'd1);
        check("on3_busy_end", busy, 64'd0);

        // BLINK n=2: 8 on, 8 off, twice; one done.
        lc = light_cnt; dc = done_cnt;
        put(5'd29, 32'h3000_0002);
        idle(40);
        check("blink_light_cycles", light_cnt - lc, 64'd16);
        check("blink_dones", done_cnt - dc, 64'd1);

        // Fill the FIFO behind a running command; fifth queued word drops.
        dc = done_cnt; max_level = 0;
        put(5'd29, 32'h1000_0005);
        idle(2);
        repeat (5) put(5'd29, 32'h1000_0002);
        idle(1);
        check("ovf_level", fifo_level, 64'd4);
        check("ovf_flag", overflow, 64'd1);
        idle(70);
        check("ovf_max_level", max_level, 64'd4);
        check("ovf_dones", done_cnt - dc, 64'd5);
        check("ovf_sticky", overflow, 64'd1);

        // CLEAR while ON n=100 runs with two queued.
        repeat (3) put(5'd29, 32'h1000_0064);
        idle(5);
        check("clr_pre_level", fifo_level, 64'd2);
        check("clr_pre_light", light, 64'd1);
        dc = done_cnt;
        put(5'd29, 32'h4000_0000);
        idle(1);
        check("clr_light", light, 64'd0);
        check("clr_level", fifo_level, 64'd0);
        check("clr_overflow", overflow, 64'd0);
        check("clr_busy", busy, 64'd0);
        idle(20);
        check("clr_no_done", done_cnt - dc, 64'd0);

        // Other registers and non-queued opcodes are ignored.
        lc = light_cnt; bc = busy_cnt;
        put(5'd28, 32'h1000_0005);
        put(5'd29, 32'h0000_0007);
        put(5'd29, 32'h5000_0003);
        put(5'd29, 32'hF000_0001);
        idle(5);
        check("ign_light", light_cnt - lc, 64'd0);
        check("ign_busy", busy_cnt - bc, 64'd0);
        check("ign_level", fifo_level, 64'd0);

        // Reserved bits [27:24] do not change the command.
        lc = light_cnt;
        put(5'd29, 32'h1F00_0001);
        idle(10);
        check("rsv_light_cycles", light_cnt - lc, 64'd4);

        // ON n=0: done pulses one cycle after the load edge, light stays low.
        lc = light_cnt; dc = done_cnt;
        put(5'd29, 32'h1000_0000);
        idle(2);
        check("n0_done", done, 64'd1);
        check("n0_light", light, 64'd0);
        idle(3);
        check("n0_dones", done_cnt - dc, 64'd1);
        check("n0_light_cycles", light_cnt - lc, 64'd0);

        // Reset in the middle of ON n=50.
        dc = done_cnt;
        put(5'd29, 32'h1000_0032);
        idle(10);
        check("rst_mid_light_pre", light, 64'd1);
        step(1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0);
        check("rst_mid_status", status, 64'd0);
        check("rst_mid_light", light, 64'd0);
        check("rst_mid_done", done, 64'd0);
        idle(3);
        check("rst_mid_no_done", done_cnt - dc, 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            int          r;
            int          w;
            logic [3:0]  op;
            logic [4:0]  rd;
            logic [31:0] data;
            r = $urandom_range(0, 99);
            if (r < 30) begin
                rd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd29;
                w  = $urandom_range(0, 19);
                if (w < 6)       op = 4'd1;
                else if (w < 10) op = 4'd2;
                else if (w < 14) op = 4'd3;
                else if (w == 14) op = 4'd4;
                else             op = 4'($urandom_range(0, 15));
                data = {op, 4'($urandom_range(0, 15)), 24'($urandom_range(0, 3))};
                put(rd, data);
            end else if (r == 30) begin
                step(1'b0, 1'b0, 5'd0, 32'd0);
            end else begin
                idle(1);
            end
        end
        idle(120);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
